fetch_queue: RTL
================

# fetch_queue

Parametrised instruction prefetch queue between the fetch-stage PC logic and decode, for the next-generation core with a variable-latency instruction memory. It issues sequential fetch requests over a request/grant port, buffers in-order responses with their PCs in a DEPTH-entry FIFO, and presents them to decode with a valid/ready handshake. On a branch or jump redirect it flushes the queue and discards responses still in flight.

## Interface
- XLEN, 32, address width
- ILEN, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2; also the maximum of (occupancy + outstanding)
- RESET_PC, 0, first fetch address after reset
- i_clk  in  1  clock; all state updates on rising edge
- i_nrst  in  1  reset, synchronous, active-low
- i_con_redirect  in  1  flush and restart fetching at i_addr_redirect
- i_addr_redirect  in  XLEN  redirect target
- o_con_req  out  1  fetch request valid
- o_addr_req  out  XLEN  fetch address
- i_con_gnt  in  1  memory accepts the request this cycle
- i_con_rvalid  in  1  response valid; in order, ≥1 cycle after its grant
- i_data_rdata  in  ILEN  response instruction
- o_con_valid  out  1  head entry valid to decode
- o_data_instr  out  ILEN  head instruction
- o_addr_pc  out  XLEN  head PC
- o_addr_pc4  out  XLEN  head PC + 4, modulo 2^XLEN
- i_con_ready  in  1  decode accepts head (pop when o_con_valid & i_con_ready)
- o_data_count  out  clog2(DEPTH+1)  FIFO occupancy

## Operation
- FSM: S_IDLE → S_RUN → S_DISCARD.
  - S_IDLE: entered on reset; no requests; always → S_RUN next cycle.
  - S_RUN: fetch normally; redirect with outstanding-after-cycle > 0 → S_DISCARD, else stay.
  - S_DISCARD: each rvalid decrements discard counter and is dropped; → S_RUN when counter reaches 0 on that edge. A further redirect reloads the counter.
- Credit rule: o_con_req = (state ≠ S_IDLE) & !i_con_redirect & (count + outstanding < DEPTH).
- On req & gnt: outstanding++, request PC pushed to an in-order pending-PC queue, o_addr_req += 4.
- On accepted rvalid (not discarded): pending PC and rdata written to FIFO tail; outstanding--.
- Redirect: FIFO cleared (count = 0), o_addr_req ← i_addr_redirect, discard ← outstanding − i_con_rvalid, pending-PC queue cleared; outstanding unchanged except for the same-cycle rvalid.
- Push and pop in the same cycle: count unchanged. FIFO cannot overflow by the credit rule; rvalid with outstanding = 0 is a protocol violation (assertion).
- Pointers wrap modulo DEPTH. Address increment wraps modulo 2^XLEN.

## Timing
- Reset values: o_con_req 0, o_addr_req RESET_PC, o_con_valid 0, o_data_instr 0, o_addr_pc 0, o_addr_pc4 0, o_data_count 0, outstanding 0, discard 0, state S_IDLE.
- o_con_req is combinational from registered state and i_con_redirect. o_addr_req is registered and held stable while req & !gnt.
- rvalid at cycle t → o_con_valid at t+1 (FIFO is registered; no bypass).
- o_con_valid forced 0 during a redirect cycle; pop ignored that cycle.
- First request in the redirect-following cycle uses i_addr_redirect.
- Reset asserted mid-operation: all state returns to reset values on that edge. Responses arriving after reset to pre-reset requests are the memory's responsibility; the memory is reset together with the queue.

## Test plan
- Reset released, memory gnt=1 and rvalid one cycle after grant, ready=1 → grants at 0,4,8,…; o_con_valid first high 3 cycles after release with o_addr_pc=0, then 4, 8 on consecutive cycles.
- ready=0, DEPTH=4 → exactly 4 grants, then o_con_req=0, o_data_count=4. A single ready pulse → one pop, exactly one new request with address 0x10.
- gnt=0 for 5 cycles at address 0x8 → o_con_req=1 and o_addr_req=0x8 held for all 5 cycles; one grant when gnt returns.
- 3 outstanding, redirect to 0x100 → next 3 rvalids dropped; first o_con_valid has o_addr_pc=0x100 and o_addr_pc4=0x104; o_data_count=0 on the cycle after the redirect.
- Redirect coinciding with rvalid and a pop, 2 outstanding → discard=1. Exactly one later response is dropped; popped entry is not re-presented.
- i_nrst low for 1 cycle mid-stream with count=3 → next cycle all outputs at reset values; then S_IDLE one cycle, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch queue between fetch-stage PC logic and decode.
// Issues sequential fetch requests over a request/grant port, buffers the
// in-order responses together with their PCs in a DEPTH-entry FIFO and hands
// them to decode with a valid/ready handshake. A redirect flushes the FIFO,
// restarts fetching at the redirect target and drops every response that is
// still in flight from before the redirect.
//
// Ports
//   i_clk, i_nrst              clock, synchronous active-low reset
//   i_con_redirect/addr        flush and restart fetching at i_addr_redirect
//   o_con_req/o_addr_req       fetch request and its address (registered)
//   i_con_gnt                  memory accepts the current request
//   i_con_rvalid/i_data_rdata  in-order response from memory
//   o_con_valid/o_data_instr   head entry presented to decode
//   o_addr_pc/o_addr_pc4       head PC and head PC + 4
//   i_con_ready                decode accepts the head entry
//   o_data_count               FIFO occupancy
// ---------------------------------------------------------------------------
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                         i_clk,
  input  logic                         i_nrst,
  input  logic                         i_con_redirect,
  input  logic [XLEN-1:0]              i_addr_redirect,
  output logic                         o_con_req,
  output logic [XLEN-1:0]              o_addr_req,
  input  logic                         i_con_gnt,
  input  logic                         i_con_rvalid,
  input  logic [ILEN-1:0]              i_data_rdata,
  output logic                         o_con_valid,
  output logic [ILEN-1:0]              o_data_instr,
  output logic [XLEN-1:0]              o_addr_pc,
  output logic [XLEN-1:0]              o_addr_pc4,
  input  logic                         i_con_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_data_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_req_q, addr_req_d;
  logic [CW-1:0]   out_q, out_d;          // requests granted, response not yet seen
  logic [CW-1:0]   discard_q, discard_d;  // responses still to be dropped
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   pq_wr_q, pq_wr_d;      // pending-PC queue pointers
  logic [PW-1:0]   pq_rd_q, pq_rd_d;

  logic [ILEN-1:0] fifo_instr_mem [DEPTH];
  logic [XLEN-1:0] fifo_pc_mem    [DEPTH];
  logic [XLEN-1:0] pq_mem         [DEPTH];

  logic [CW:0] credit_sum;
  logic        head_valid;
  logic        grant;
  logic        accept;
  logic        pop;

  // Occupancy plus in-flight requests never exceeds DEPTH, so every granted
  // request is guaranteed a FIFO slot when its response returns.
  assign credit_sum = {1'b0, count_q} + {1'b0, out_q};
  assign o_con_req  = (state_q != S_IDLE) && !i_con_redirect && (credit_sum < DEPTH_C);
  assign grant      = o_con_req && i_con_gnt;

  // Responses are only kept in S_RUN; in S_DISCARD they belong to requests
  // issued before the last redirect. Pending PCs are therefore only consumed
  // for kept responses.
  assign accept     = i_con_rvalid && (state_q == S_RUN) && !i_con_redirect;

  assign head_valid = (count_q != '0);
  assign o_con_valid = head_valid && !i_con_redirect;
  assign pop        = o_con_valid && i_con_ready;

  assign o_addr_req   = addr_req_q;
  assign o_data_count = count_q;
  assign o_data_instr = head_valid ? fifo_instr_mem[rd_ptr_q] : '0;
  assign o_addr_pc    = head_valid ? fifo_pc_mem[rd_ptr_q] : '0;
  assign o_addr_pc4   = head_valid ? (fifo_pc_mem[rd_ptr_q] + XLEN'(4)) : '0;

  always_comb begin
    state_d    = state_q;
    addr_req_d = addr_req_q;
    out_d      = out_q + CW'(grant) - CW'(i_con_rvalid);
    discard_d  = discard_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    pq_wr_d    = pq_wr_q;
    pq_rd_d    = pq_rd_q;

    if (grant) begin
      addr_req_d = addr_req_q + XLEN'(4);
      pq_wr_d    = pq_wr_q + PW'(1);
    end

    if (i_con_redirect) begin
      // No request is issued in a redirect cycle, so the address and pending
      // queue can be reloaded without colliding with a grant.
      addr_req_d = i_addr_redirect;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pq_wr_d    = '0;
      pq_rd_d    = '0;
      discard_d  = out_q - CW'(i_con_rvalid);
      state_d    = (discard_d != '0) ? S_DISCARD : S_RUN;
    end else begin
      if (accept) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        pq_rd_d  = pq_rd_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(accept) - CW'(pop);

      case (state_q)
        S_IDLE: state_d = S_RUN;
        S_RUN:  state_d = S_RUN;
        S_DISCARD: begin
          if (i_con_rvalid) begin
            discard_d = discard_q - CW'(1);
            if (discard_q == CW'(1)) begin
              state_d = S_RUN;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q    <= S_IDLE;
      addr_req_q <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pq_wr_q    <= '0;
      pq_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_req_q <= addr_req_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pq_wr_q    <= pq_wr_d;
      pq_rd_q    <= pq_rd_d;
    end
  end

  // Storage arrays carry no reset; the occupancy counters decide what is live.
  always_ff @(posedge i_clk) begin
    if (grant) begin
      pq_mem[pq_wr_q] <= addr_req_q;
    end
    if (accept) begin
      fifo_instr_mem[wr_ptr_q] <= i_data_rdata;
      fifo_pc_mem[wr_ptr_q]    <= pq_mem[pq_rd_q];
    end
  end

  // A response with nothing outstanding means the memory broke the protocol.
  a_rvalid_has_request : assert property (
    @(posedge i_clk) disable iff (!i_nrst) i_con_rvalid |-> (out_q != '0)
  );

endmodule
